// File: rtl/mul_16_bit.sv
// Two-stage 16x16 -> 32 multiplier: 8x8 partial products, then shift-add tree.
// Define MUL16_SIGNED_EN for two's-complement operands and a signed product.
module mul_16_bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    output logic [31:0] P,
    output logic        C
);

    // 8x8 unsigned product assembled from four 4x4 sub-products
    function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p0, p1, p2, p3;
        p0 = {4'b0, x[3:0]} * {4'b0, y[3:0]};
        p1 = {4'b0, x[3:0]} * {4'b0, y[7:4]};
        p2 = {4'b0, x[7:4]} * {4'b0, y[3:0]};
        p3 = {4'b0, x[7:4]} * {4'b0, y[7:4]};
        return {8'b0, p0} + {4'b0, p1, 4'b0} + {4'b0, p2, 4'b0} + {p3, 8'b0};
    endfunction

    logic [15:0] ll_u, lh_u, hl_u, hh_u;
    logic [15:0] ll_c, hh_c;
    logic [16:0] lh_c, hl_c;

    logic        v1;
    logic [15:0] ll_q, hh_q;
    logic [16:0] lh_q, hl_q;

    logic [31:0] lh_x, hl_x, mid, sum;
    logic        ovf;

    assign ll_u = mul8(A[7:0],  B[7:0]);
    assign lh_u = mul8(A[7:0],  B[15:8]);
    assign hl_u = mul8(A[15:8], B[7:0]);
    assign hh_u = mul8(A[15:8], B[15:8]);
    assign ll_c = ll_u;

`ifdef MUL16_SIGNED_EN
    // Upper halves carry weight -2^7 on their MSB; the 2^32 term of HH drops out
    assign lh_c = {1'b0, lh_u} - (B[15] ? {1'b0, A[7:0], 8'b0} : 17'd0);
    assign hl_c = {1'b0, hl_u} - (A[15] ? {1'b0, B[7:0], 8'b0} : 17'd0);
    assign hh_c = hh_u - (A[15] ? {B[15:8], 8'b0} : 16'd0)
                       - (B[15] ? {A[15:8], 8'b0} : 16'd0);
    assign lh_x = {{15{lh_q[16]}}, lh_q};
    assign hl_x = {{15{hl_q[16]}}, hl_q};
`else
    assign lh_c = {1'b0, lh_u};
    assign hl_c = {1'b0, hl_u};
    assign hh_c = hh_u;
    assign lh_x = {15'b0, lh_q};
    assign hl_x = {15'b0, hl_q};
`endif

    assign mid = lh_x + hl_x;
    assign sum = {16'b0, ll_q} + (mid << 8) + {hh_q, 16'b0};

`ifdef MUL16_SIGNED_EN
    assign ovf = ~((&sum[31:15]) | ~(|sum[31:15]));
`else
    assign ovf = |sum[31:16];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            ll_q      <= '0;
            lh_q      <= '0;
            hl_q      <= '0;
            hh_q      <= '0;
            out_valid <= 1'b0;
            P         <= '0;
            C         <= 1'b0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                ll_q <= ll_c;
                lh_q <= lh_c;
                hl_q <= hl_c;
                hh_q <= hh_c;
            end
            if (v1) begin
                P <= sum;
                C <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_mul_16_bit.sv
// Scoreboard bench for mul_16_bit; follows MUL16_SIGNED_EN for the reference.
module tb_mul_16_bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] A, B;
    logic        out_valid;
    logic [31:0] P;
    logic        C;

    int tests = 0;
    int fails = 0;
    int run = 0;
    int last_run = 0;

    typedef struct packed {
        logic [31:0] p;
        logic        c;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    mul_16_bit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(A), .B(B), .out_valid(out_valid), .P(P), .C(C)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint x;
`ifdef MUL16_SIGNED_EN
        x   = longint'($signed(a)) * longint'($signed(b));
        e.c = (x < -32768) || (x > 32767);
`else
        x   = longint'(a) * longint'(b);
        e.c = (x > 65535);
`endif
        e.p = x[31:0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        A = a;
        B = b;
        q.push_back(model(a, b));
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            run++;
            if (q.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("P", P, e.p);
                chk("C", {31'b0, C}, {31'b0, e.c});
            end
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        A = 16'h1234;
        B = 16'h5678;
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_P", P, 32'd0);
            chk("rst_C", {31'b0, C}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;

        issue(16'd3, 16'd5);
        issue(16'hFFFF, 16'hFFFF);
        issue(16'h0100, 16'h0100);
        issue(16'h0000, 16'hBEEF);
        idle(4);
        chk("basic_drain", q.size(), 32'd0);
        chk("basic_burst", last_run, 32'd4);

        issue(16'd7, 16'd9);
        idle(5);
        chk("hold_P", P, 32'd63);
        chk("hold_out_valid", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 10; i++)
            issue(16'($urandom), 16'($urandom));
        idle(4);
        chk("burst_drain", q.size(), 32'd0);
        chk("burst_len", last_run, 32'd10);

        @(posedge clk);
        #1;
        in_valid = 1'b1;
        A = 16'd2;
        B = 16'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("flight_out_valid", {31'b0, out_valid}, 32'd0);
            chk("flight_P", P, 32'd0);
        end

`ifdef MUL16_SIGNED_EN
        issue(16'hFFFF, 16'h0002);
        issue(16'h8000, 16'h8000);
        issue(16'h8000, 16'h7FFF);
        idle(4);
        chk("signed_drain", q.size(), 32'd0);
`endif

        issue(16'h00FF, 16'h0101);
        issue(16'h8001, 16'h0003);
        idle(4);
        chk("final_drain", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
